soc_timer_event_arbiter: RTL and testbench
==========================================

Name: soc_timer_event_arbiter

Overview:
- Round-robin AXI-Stream arbiter that merges the event streams of up to NUM_SRC soc_timer stream channels into one master stream.
- The master stream feeds the DMA/logging path.
- Each output beat is tagged with its source index on M_TID.
- A grant is packet-locked: it is held from the first beat to the TLAST beat.
- The output is fully registered.

Parameters:
NUM_SRC, 4, number of slave stream inputs (2..16)
DATA_WIDTH, 32, TDATA width of every stream
ID_WIDTH, 2, width of M_TID; must be at least ceil(log2(NUM_SRC)), minimum 1

Ports:
ACLK  input  1  clock; all logic on rising edge
ARESET  input  1  synchronous, active-high reset
S_TDATA  input  NUM_SRC*DATA_WIDTH  packed slave data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
S_TVALID  input  NUM_SRC  per-source valid
S_TREADY  output  NUM_SRC  per-source ready
S_TLAST  input  NUM_SRC  per-source end of packet
src_enable  input  NUM_SRC  per-source arbitration enable; 0 = source never newly granted
M_TDATA  output  DATA_WIDTH  merged data
M_TID  output  ID_WIDTH  index of the source that produced the beat
M_TVALID  output  1  master valid
M_TREADY  input  1  master ready
M_TLAST  output  1  copy of the accepted beat's S_TLAST
busy  output  1  1 when state is GRANT or M_TVALID=1

Behaviour:
- Reset (ARESET=1 at a rising edge):
  - state=IDLE, rr_ptr=0, grant=0.
  - M_TVALID=0, M_TDATA=0, M_TID=0, M_TLAST=0.
  - S_TREADY=0; busy=0.
  - Reset mid-packet discards the output register and the lock. No beat is replayed.
- req = S_TVALID & src_enable.
- IDLE:
  - S_TREADY is all zeros.
  - If req is nonzero, select the first set bit scanning from index rr_ptr upward, wrapping modulo NUM_SRC.
  - On that edge: grant <= selected index, state <= GRANT.
  - If req is zero, remain in IDLE.
- GRANT:
  - out_free = !M_TVALID || M_TREADY.
  - S_TREADY[grant] = out_free; all other S_TREADY bits = 0. This is combinational from state, grant, M_TVALID and M_TREADY.
  - A beat is accepted when S_TVALID[grant] && S_TREADY[grant]. On acceptance:
    - M_TDATA <= slice[grant], M_TID <= grant, M_TLAST <= S_TLAST[grant], M_TVALID <= 1.
  - Accepted beat with S_TLAST=1: state <= IDLE, rr_ptr <= (grant+1) mod NUM_SRC.
  - Otherwise stay in GRANT. The lock holds even if src_enable[grant] drops or S_TVALID[grant] deasserts.
- Output register:
  - If M_TVALID && M_TREADY and no new beat is accepted on that edge: M_TVALID <= 0.
  - M_TDATA, M_TID and M_TLAST are stable while M_TVALID=1 && M_TREADY=0.
- Latency and throughput:
  - A request seen in IDLE at cycle 0 gives grant at edge 1 and S_TREADY high in cycle 1.
  - The beat is accepted at edge 2 and M_TVALID is high in cycle 2.
  - Single-beat packets: at most one packet per 2 cycles (arbitration cycle + transfer cycle).
  - Beats within a packet: 1 per cycle while M_TREADY=1.
- Fairness:
  - A source granted last has lowest priority at the next arbitration.
  - With all NUM_SRC sources continuously requesting, each is served once per NUM_SRC packets.
- Boundary cases:
  - grant = NUM_SRC-1 at TLAST wraps rr_ptr to 0.
  - NUM_SRC not a power of two: the wrap is still modulo NUM_SRC; unused ID codes are never produced.
  - Output stalled (M_TVALID=1, M_TREADY=0): S_TREADY[grant]=0 and no beat is lost.
  - Same cycle M_TREADY=1 and new beat accepted: M_TVALID stays 1 with the new data (no bubble).
  - req changing while in GRANT has no effect until return to IDLE.

Test Plan:
1. Reset: hold ARESET 2 cycles with all S_TVALID=1 -> M_TVALID=0, S_TREADY=0000, busy=0; first grant after release goes to source 0.
2. Single request: src 2 sends TDATA=0x0000_0005, TLAST=1, M_TREADY=1 -> M_TVALID high exactly 2 cycles after S_TVALID; M_TDATA=5, M_TID=2, M_TLAST=1; S_TREADY=0100 for one cycle.
3. Round-robin: all 4 sources continuously valid with single-beat packets, TDATA=source index, M_TREADY=1 -> M_TID sequence 0,1,2,3,0,1,...; one beat every 2 cycles.
4. Packet lock: src 1 sends a 3-beat packet (0xA,0xB,0xC, TLAST on 0xC) while src 0 is valid -> three consecutive M_TID=1 beats, then src 0 served; rr_ptr=2 after the packet.
5. Backpressure: M_TREADY=0 for 5 cycles during src 3's 2-beat packet -> M_TDATA held constant, S_TREADY[3]=0, both beats delivered in order, none dropped.
6. Enable mask: src_enable=1010 with all sources valid -> only M_TID 1 and 3 appear, alternating; src_enable[1] cleared mid-packet -> src 1's packet still completes through TLAST.

Source files
------------

// File: rtl/soc_timer_event_arbiter.sv
// soc_timer_event_arbiter
//   Packet-locked round-robin arbiter that merges up to NUM_SRC AXI-Stream
//   event channels from the soc_timer block into a single master stream
//   for the DMA/logging path. Every output beat carries its source index on
//   M_TID. A grant is held from the first beat of a packet through its TLAST
//   beat. The master side is fully registered.
//
// Ports
//   ACLK, ARESET          clock and synchronous active-high reset
//   S_TDATA               packed slave data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   S_TVALID/S_TLAST      per-source valid and end-of-packet
//   S_TREADY              per-source ready (only the granted source can be ready)
//   src_enable            per-source arbitration enable (no new grant when 0)
//   M_TDATA/M_TID/M_TLAST registered master beat, source index, end-of-packet
//   M_TVALID/M_TREADY     master handshake
//   busy                  high while a packet is locked or a beat is pending
module soc_timer_event_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] S_TDATA,
  input  logic [NUM_SRC-1:0]            S_TVALID,
  output logic [NUM_SRC-1:0]            S_TREADY,
  input  logic [NUM_SRC-1:0]            S_TLAST,
  input  logic [NUM_SRC-1:0]            src_enable,
  output logic [DATA_WIDTH-1:0]         M_TDATA,
  output logic [ID_WIDTH-1:0]           M_TID,
  output logic                          M_TVALID,
  input  logic                          M_TREADY,
  output logic                          M_TLAST,
  output logic                          busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_reg, state_next;
  logic [ID_WIDTH-1:0]   grant_reg, grant_next;
  logic [ID_WIDTH-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic [ID_WIDTH-1:0]   id_reg, id_next;
  logic                  valid_reg, valid_next;
  logic                  last_reg, last_next;

  logic [NUM_SRC-1:0]    req;
  logic [DATA_WIDTH-1:0] slice [NUM_SRC];
  logic                  out_free;
  logic                  accept;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_idx;
  int                    scan_pos;

  assign req      = S_TVALID & src_enable;
  // The output register can take a new beat when empty or draining this cycle.
  assign out_free = !valid_reg || M_TREADY;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign slice[gi]    = S_TDATA[gi*DATA_WIDTH +: DATA_WIDTH];
      assign S_TREADY[gi] = (state_reg == GRANT) && (grant_reg == ID_WIDTH'(gi)) && out_free;
    end
  endgenerate

  // Mux out the granted source's stream signals.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (grant_reg == ID_WIDTH'(j)) begin
        g_valid = S_TVALID[j];
        g_last  = S_TLAST[j];
        g_data  = slice[j];
      end
    end
  end

  assign accept = (state_reg == GRANT) && g_valid && out_free;

  // Round-robin scan: first requester at or above rr_ptr, wrapping modulo
  // NUM_SRC (explicit subtract so non power-of-two counts wrap correctly).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_pos   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_pos = int'(rr_ptr_reg) + k;
      if (scan_pos >= NUM_SRC) begin
        scan_pos = scan_pos - NUM_SRC;
      end
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!pick_found && (scan_pos == j) && req[j]) begin
          pick_found = 1'b1;
          pick_idx   = ID_WIDTH'(j);
        end
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    data_next   = data_reg;
    id_next     = id_reg;
    last_next   = last_reg;
    valid_next  = valid_reg;

    // Drain; overridden below when a new beat lands on the same edge.
    if (valid_reg && M_TREADY) begin
      valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick_idx;
          state_next = GRANT;
        end
      end
      GRANT: begin
        // Lock is held regardless of req; only the TLAST beat releases it.
        if (accept) begin
          data_next  = g_data;
          id_next    = grant_reg;
          last_next  = g_last;
          valid_next = 1'b1;
          if (g_last) begin
            state_next = IDLE;
            if (grant_reg == ID_WIDTH'(NUM_SRC - 1)) begin
              rr_ptr_next = '0;
            end else begin
              rr_ptr_next = grant_reg + ID_WIDTH'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      data_reg   <= '0;
      id_reg     <= '0;
      valid_reg  <= 1'b0;
      last_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
      data_reg   <= data_next;
      id_reg     <= id_next;
      valid_reg  <= valid_next;
      last_reg   <= last_next;
    end
  end

  assign M_TDATA  = data_reg;
  assign M_TID    = id_reg;
  assign M_TVALID = valid_reg;
  assign M_TLAST  = last_reg;
  assign busy     = (state_reg == GRANT) || valid_reg;

endmodule

// File: tb/tb_soc_timer_event_arbiter.sv
// Testbench for soc_timer_event_arbiter (NUM_SRC=4, DATA_WIDTH=32, ID_WIDTH=2).
// A per-cycle vector table covers reset release, round-robin order and
// output backpressure; hand sequences with a small per-source packet
// player and an output beat log cover single request, packet lock,
// stalled multi-beat packets and the enable mask.
module tb_soc_timer_event_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [N*DW-1:0] S_TDATA;
  logic [N-1:0]    S_TVALID;
  logic [N-1:0]    S_TREADY;
  logic [N-1:0]    S_TLAST;
  logic [N-1:0]    src_enable;
  logic [DW-1:0]   M_TDATA;
  logic [IW-1:0]   M_TID;
  logic            M_TVALID;
  logic            M_TREADY;
  logic            M_TLAST;
  logic            busy;

  soc_timer_event_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TLAST(S_TLAST),
    .src_enable(src_enable),
    .M_TDATA(M_TDATA), .M_TID(M_TID), .M_TVALID(M_TVALID), .M_TREADY(M_TREADY),
    .M_TLAST(M_TLAST), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0]  valid;
    logic [N-1:0]  last;
    logic [N-1:0]  en;
    logic          mready;
    logic [N-1:0]  exp_stready;
    logic          exp_mvalid;
    logic [IW-1:0] exp_tid;
    logic [DW-1:0] exp_data;
    logic          exp_busy;
  } vec_t;

  vec_t tbl [16];

  // packet player state
  logic [N-1:0]  src_on;
  logic [DW-1:0] pk_data [N][8];
  logic          pk_last [N][8];
  int            pk_len  [N];
  int            pk_idx  [N];

  // output beat log and expected beats
  int            got_tid  [$];
  logic [DW-1:0] got_data [$];
  logic          got_last [$];
  int            exp_tid  [$];
  logic [DW-1:0] exp_data [$];
  logic          exp_last [$];

  function automatic vec_t mk(input logic [N-1:0] st, input logic mr, input logic mv,
                              input logic [IW-1:0] tid, input logic [DW-1:0] d, input logic b);
    vec_t v;
    v.valid = 4'b1111; v.last = 4'b1111; v.en = 4'b1111; v.mready = mr;
    v.exp_stready = st; v.exp_mvalid = mv; v.exp_tid = tid; v.exp_data = d; v.exp_busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_on[i] && (pk_idx[i] < pk_len[i])) begin
        S_TVALID[i]        = 1'b1;
        S_TDATA[i*DW +: DW] = pk_data[i][pk_idx[i]];
        S_TLAST[i]         = pk_last[i][pk_idx[i]];
      end else begin
        S_TVALID[i]        = 1'b0;
        S_TDATA[i*DW +: DW] = '0;
        S_TLAST[i]         = 1'b0;
      end
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      pk_len[i] = 0;
      pk_idx[i] = 0;
    end
    src_on = '0;
    got_tid.delete(); got_data.delete(); got_last.delete();
    exp_tid.delete(); exp_data.delete(); exp_last.delete();
  endtask

  task automatic add_beat(input int s, input logic [DW-1:0] d, input logic l);
    pk_data[s][pk_len[s]] = d;
    pk_last[s][pk_len[s]] = l;
    pk_len[s]++;
  endtask

  task automatic expect_beat(input int t, input logic [DW-1:0] d, input logic l);
    exp_tid.push_back(t); exp_data.push_back(d); exp_last.push_back(l);
  endtask

  // One clock: sample handshakes before the edge, advance players after it.
  task automatic step();
    logic [N-1:0] fire;
    #1;
    fire = S_TVALID & S_TREADY;
    if (M_TVALID && M_TREADY) begin
      got_tid.push_back(int'(M_TID)); got_data.push_back(M_TDATA); got_last.push_back(M_TLAST);
      $display("beat tid=%0d data=0x%0h last=%0d", M_TID, M_TDATA, M_TLAST);
    end
    @(posedge ACLK); #1;
    for (int i = 0; i < N; i++) if (fire[i]) pk_idx[i]++;
    drive();
    #1;
  endtask

  task automatic do_reset();
    ARESET = 1'b1; M_TREADY = 1'b1; src_enable = '1;
    clear_src(); drive();
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int c = 0;
    while ((got_tid.size() < n) && (c < budget)) begin
      step();
      c++;
    end
    checks++;
    if (got_tid.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d beats expected %0d", name, got_tid.size(), n);
    end
  endtask

  task automatic check_log(input string name);
    chk($sformatf("%s_count", name), 64'(got_tid.size()), 64'(exp_tid.size()));
    for (int i = 0; i < exp_tid.size(); i++) begin
      if (i < got_tid.size()) begin
        chk($sformatf("%s_tid%0d", name, i), 64'(got_tid[i]), 64'(exp_tid[i]));
        chk($sformatf("%s_data%0d", name, i), 64'(got_data[i]), 64'(exp_data[i]));
        chk($sformatf("%s_last%0d", name, i), 64'(got_last[i]), 64'(exp_last[i]));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Round-robin with all four sources valid, single-beat packets, TDATA=index.
    // Rows 11..15 add output backpressure and the no-bubble reload.
    tbl[0]  = mk(4'b0000, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
    tbl[1]  = mk(4'b0001, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1);
    tbl[2]  = mk(4'b0000, 1'b1, 1'b1, 2'd0, 32'd0, 1'b1);
    tbl[3]  = mk(4'b0010, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1);
    tbl[4]  = mk(4'b0000, 1'b1, 1'b1, 2'd1, 32'd1, 1'b1);
    tbl[5]  = mk(4'b0100, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1);
    tbl[6]  = mk(4'b0000, 1'b1, 1'b1, 2'd2, 32'd2, 1'b1);
    tbl[7]  = mk(4'b1000, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1);
    tbl[8]  = mk(4'b0000, 1'b1, 1'b1, 2'd3, 32'd3, 1'b1);
    tbl[9]  = mk(4'b0001, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1);
    tbl[10] = mk(4'b0000, 1'b1, 1'b1, 2'd0, 32'd0, 1'b1);
    tbl[11] = mk(4'b0010, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
    tbl[12] = mk(4'b0000, 1'b0, 1'b1, 2'd1, 32'd1, 1'b1);
    tbl[13] = mk(4'b0000, 1'b0, 1'b1, 2'd1, 32'd1, 1'b1);
    tbl[14] = mk(4'b0100, 1'b1, 1'b1, 2'd1, 32'd1, 1'b1);
    tbl[15] = mk(4'b0000, 1'b1, 1'b1, 2'd2, 32'd2, 1'b1);

    // Reset held two cycles with every source valid.
    ARESET = 1'b1; M_TREADY = 1'b1; src_enable = 4'b1111;
    S_TVALID = 4'b1111; S_TLAST = 4'b1111;
    S_TDATA = {32'd3, 32'd2, 32'd1, 32'd0};
    src_on = '0;
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_mvalid", 64'(M_TVALID), 64'd0);
    chk("rst_stready", 64'(S_TREADY), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mdata", 64'(M_TDATA), 64'd0);
    chk("rst_mtid", 64'(M_TID), 64'd0);
    chk("rst_mlast", 64'(M_TLAST), 64'd0);
    ARESET = 1'b0;

    for (int r = 0; r < 16; r++) begin
      S_TVALID = tbl[r].valid; S_TLAST = tbl[r].last;
      src_enable = tbl[r].en; M_TREADY = tbl[r].mready;
      #1;
      chk($sformatf("rr%0d_stready", r), 64'(S_TREADY), 64'(tbl[r].exp_stready));
      chk($sformatf("rr%0d_mvalid", r), 64'(M_TVALID), 64'(tbl[r].exp_mvalid));
      chk($sformatf("rr%0d_busy", r), 64'(busy), 64'(tbl[r].exp_busy));
      if (tbl[r].exp_mvalid) begin
        chk($sformatf("rr%0d_tid", r), 64'(M_TID), 64'(tbl[r].exp_tid));
        chk($sformatf("rr%0d_data", r), 64'(M_TDATA), 64'(tbl[r].exp_data));
        chk($sformatf("rr%0d_last", r), 64'(M_TLAST), 64'd1);
      end
      $display("row %0d stready=%b mvalid=%0d tid=%0d data=0x%0h busy=%0d",
               r, S_TREADY, M_TVALID, M_TID, M_TDATA, busy);
      @(posedge ACLK); #1;
    end

    // Single request from source 2.
    do_reset();
    add_beat(2, 32'h0000_0005, 1'b1);
    src_on = 4'b0100; drive(); #1;
    chk("single_c0_stready", 64'(S_TREADY), 64'd0);
    chk("single_c0_mvalid", 64'(M_TVALID), 64'd0);
    step();
    chk("single_c1_stready", 64'(S_TREADY), 64'b0100);
    chk("single_c1_mvalid", 64'(M_TVALID), 64'd0);
    step();
    chk("single_c2_mvalid", 64'(M_TVALID), 64'd1);
    chk("single_c2_data", 64'(M_TDATA), 64'h5);
    chk("single_c2_tid", 64'(M_TID), 64'd2);
    chk("single_c2_last", 64'(M_TLAST), 64'd1);
    chk("single_c2_stready", 64'(S_TREADY), 64'd0);
    step();
    chk("single_c3_mvalid", 64'(M_TVALID), 64'd0);
    chk("single_c3_busy", 64'(busy), 64'd0);

    // Packet lock: source 1 holds the grant for 3 beats while 0 and 3 wait;
    // rr_ptr then points at 2, so 3 is served before 0.
    do_reset();
    add_beat(1, 32'hA, 1'b0); add_beat(1, 32'hB, 1'b0); add_beat(1, 32'hC, 1'b1);
    add_beat(0, 32'h100, 1'b1); add_beat(3, 32'h300, 1'b1);
    src_on = 4'b0010; drive();
    step();
    src_on = 4'b1011; drive();
    expect_beat(1, 32'hA, 1'b0); expect_beat(1, 32'hB, 1'b0); expect_beat(1, 32'hC, 1'b1);
    expect_beat(3, 32'h300, 1'b1); expect_beat(0, 32'h100, 1'b1);
    run_until(5, 40, "lock");
    check_log("lock");

    // Backpressure during source 3's 2-beat packet.
    do_reset();
    add_beat(3, 32'h33, 1'b0); add_beat(3, 32'h44, 1'b1);
    src_on = 4'b1000; drive();
    step();
    chk("bp_stready_grant", 64'(S_TREADY), 64'b1000);
    M_TREADY = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d_mvalid", i), 64'(M_TVALID), 64'd1);
      chk($sformatf("bp_hold%0d_data", i), 64'(M_TDATA), 64'h33);
      chk($sformatf("bp_hold%0d_stready", i), 64'(S_TREADY), 64'd0);
      step();
    end
    M_TREADY = 1'b1;
    step();
    chk("bp_nobubble_mvalid", 64'(M_TVALID), 64'd1);
    chk("bp_nobubble_data", 64'(M_TDATA), 64'h44);
    chk("bp_nobubble_last", 64'(M_TLAST), 64'd1);
    step();
    expect_beat(3, 32'h33, 1'b0); expect_beat(3, 32'h44, 1'b1);
    check_log("bp");

    // Enable mask 1010: only sources 1 and 3, alternating.
    do_reset();
    for (int s = 0; s < N; s++)
      for (int k = 0; k < 4; k++) add_beat(s, 32'(s * 16 + k), 1'b1);
    src_enable = 4'b1010; src_on = 4'b1111; drive();
    for (int k = 0; k < 3; k++) begin
      expect_beat(1, 32'(16 + k), 1'b1);
      expect_beat(3, 32'(48 + k), 1'b1);
    end
    run_until(6, 60, "mask");
    check_log("mask");

    // Enable of the locked source dropped mid-packet: packet still completes.
    do_reset();
    add_beat(1, 32'h51, 1'b0); add_beat(1, 32'h52, 1'b0); add_beat(1, 32'h53, 1'b1);
    add_beat(3, 32'h70, 1'b1);
    src_enable = 4'b1010; src_on = 4'b1010; drive();
    step();
    step();
    src_enable = 4'b1000;
    expect_beat(1, 32'h51, 1'b0); expect_beat(1, 32'h52, 1'b0); expect_beat(1, 32'h53, 1'b1);
    expect_beat(3, 32'h70, 1'b1);
    run_until(4, 40, "endrop");
    check_log("endrop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
